// File: rtl/credit_switch_allocator.sv
// ---------------------------------------------------------------------------
// credit_switch_allocator
//
// Per-output round-robin switch allocator with credit-based downstream flow
// control for the mesh router. Each output keeps a credit counter mirroring
// the free space in the downstream input queue. An input may only win an
// output while that output has at least one credit.
//
// Ports:
//   clk              - clock
//   reset_n          - asynchronous active-low reset
//   i_output_req     - [input][output] request matrix, expected one-hot per row
//   i_credit_return  - per-output pulse, one per packet popped downstream
//   o_output_grant   - [output][input] one-hot input select for the switch
//   o_input_grant    - per-input FIFO read enable
//   o_credit_count   - registered credit count per output
//   o_credit_err     - sticky flag for attempted credit overflow/underflow
//
// Port and matrix ranges are ascending, so index 0 (local port) is the MSB
// of each packed vector.
// ---------------------------------------------------------------------------
module credit_switch_allocator #(
    parameter int N            = 5,
    parameter int M            = 5,
    parameter int CREDIT_DEPTH = 4,
    localparam int CW          = $clog2(CREDIT_DEPTH + 1),
    localparam int PW          = (N > 1) ? $clog2(N) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [0:N-1][0:M-1]     i_output_req,
    input  logic [0:M-1]            i_credit_return,
    output logic [0:M-1][0:N-1]     o_output_grant,
    output logic [0:N-1]            o_input_grant,
    output logic [0:M-1][CW-1:0]    o_credit_count,
    output logic                    o_credit_err
);

    logic [0:M-1][CW-1:0] r_credit;
    logic [0:M-1][PW-1:0] r_rrPtr;
    logic                 r_creditErr;

    logic [0:N-1][0:M-1]  w_maskedReq;
    logic [0:M-1][0:N-1]  w_grant;
    logic [0:M-1]         w_granted;
    logic [0:M-1][PW-1:0] w_grantIdx;
    logic [0:N-1]         w_inputGrant;

    // Modulo-N wrap for a scan position that is at most 2N-2.
    function automatic int wrapIdx(input int a);
        return (a >= N) ? a - N : a;
    endfunction

    // Keep only the lowest-index output of each request row so that an input
    // can never win more than one output in a cycle.
    always_comb begin
        w_maskedReq = '0;
        for (int i = 0; i < N; i++) begin
            for (int o = 0; o < M; o++) begin
                if (i_output_req[i][o] && (w_maskedReq[i] == '0)) begin
                    w_maskedReq[i][o] = 1'b1;
                end
            end
        end
    end

    // Round-robin scan per output starting at its pointer; an output with no
    // credits grants nobody.
    always_comb begin
        w_grant    = '0;
        w_granted  = '0;
        w_grantIdx = '0;
        for (int o = 0; o < M; o++) begin
            if (r_credit[o] != '0) begin
                for (int k = 0; k < N; k++) begin
                    if (!w_granted[o] && w_maskedReq[wrapIdx(int'(r_rrPtr[o]) + k)][o]) begin
                        w_grant[o][wrapIdx(int'(r_rrPtr[o]) + k)] = 1'b1;
                        w_granted[o]  = 1'b1;
                        w_grantIdx[o] = PW'(wrapIdx(int'(r_rrPtr[o]) + k));
                    end
                end
            end
        end
    end

    // Grants are suppressed while reset is held, independent of requests.
    assign o_output_grant = reset_n ? w_grant : '0;

    always_comb begin
        w_inputGrant = '0;
        for (int o = 0; o < M; o++) begin
            for (int i = 0; i < N; i++) begin
                w_inputGrant[i] = w_inputGrant[i] | o_output_grant[o][i];
            end
        end
    end

    assign o_input_grant = w_inputGrant;

    // Pointer advances past the winner; credits move by grant/return with
    // saturation, and any attempt to leave the legal range flags an error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int o = 0; o < M; o++) begin
                r_credit[o] <= CW'(CREDIT_DEPTH);
            end
            r_rrPtr     <= '0;
            r_creditErr <= 1'b0;
        end else begin
            for (int o = 0; o < M; o++) begin
                if (w_granted[o]) begin
                    r_rrPtr[o] <= (w_grantIdx[o] == PW'(N - 1)) ? '0 : w_grantIdx[o] + 1'b1;
                end
                if (w_granted[o] && !i_credit_return[o]) begin
                    if (r_credit[o] == '0) begin
                        r_creditErr <= 1'b1;
                    end else begin
                        r_credit[o] <= r_credit[o] - 1'b1;
                    end
                end else if (!w_granted[o] && i_credit_return[o]) begin
                    if (r_credit[o] == CW'(CREDIT_DEPTH)) begin
                        r_creditErr <= 1'b1;
                    end else begin
                        r_credit[o] <= r_credit[o] + 1'b1;
                    end
                end
            end
        end
    end

    assign o_credit_count = r_credit;
    assign o_credit_err   = r_creditErr;

endmodule
